// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: eight-source interrupt controller on the Z80 core's Wishbone
// I/O bus. It latches rising edges on irq lines into PEND, gates them with MASK
// and a global enable, and drives int_req_o. It also answers the core's
// interrupt-acknowledge cycle with a mode-2 vector
// {VBASE[7:4], idx, 0}, or {VBASE[7:4], 4'hF} when the acknowledge is spurious.
//
// Register map (offset = wb_adr_i[1:0]):
//   0 PEND  R/W1C  edge-latched requests
//   1 MASK  R/W    1 blocks the source (PEND still records it)
//   2 VBASE R/W    vector base, bits [7:4] used in vectors
//   3 CTRL         bit0 EN (R/W), bit3 VALID (RO), bits[6:4] LAST (RO)

module z80_int_ctrl #(
    parameter logic [7:0] IO_BASE = 8'hF0,
    parameter logic [1:0] TGA_IO  = 2'b01,
    parameter logic [1:0] TGA_INT = 2'b10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_tga_i,
    output logic        wb_ack_o,
    input  logic [7:0]  irq_i,
    output logic        int_req_o
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Index of the lowest set bit; bit 0 has the highest priority.
    // Returns 0 for an all-zero vector (callers qualify with |vec).
    function automatic logic [2:0] lowest_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [7:0]  irq_d_r;
    logic [7:0]  pend_r;
    logic [7:0]  mask_r;
    logic [7:0]  vbase_r;
    logic        en_r;
    logic        valid_r;
    logic [2:0]  last_r;
    logic        ack_r;
    logic [7:0]  dat_r;
    logic        int_req_r;

    logic        io_hit_s;
    logic        int_hit_s;
    logic        accept_s;
    logic        io_acc_s;
    logic        int_acc_s;
    logic        wr_s;
    logic [1:0]  offset_s;
    logic [7:0]  edge_s;
    logic [7:0]  active_s;
    logic        any_active_s;
    logic [2:0]  idx_s;
    logic [7:0]  ctrl_rd_s;
    logic [7:0]  rd_data_s;
    logic [7:0]  vector_s;
    logic [7:0]  out_data_s;
    logic [7:0]  pend_w1c_s;
    logic [7:0]  pend_ack_clr_s;
    logic [7:0]  pend_next_s;
    logic        unused_adr_s;

    // Upper address byte is decoded elsewhere on the bus.
    assign unused_adr_s = ^wb_adr_i[15:8];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------

    assign offset_s     = wb_adr_i[1:0];
    assign io_hit_s     = (wb_tga_i == TGA_IO) && (wb_adr_i[7:2] == IO_BASE[7:2]);
    assign int_hit_s    = (wb_tga_i == TGA_INT);
    assign edge_s       = irq_i & ~irq_d_r;
    assign active_s     = pend_r & ~mask_r;
    assign any_active_s = |active_s;
    assign idx_s        = lowest_index(active_s);
    assign ctrl_rd_s    = {1'b0, last_r, valid_r, 2'b00, en_r};

    // Slave FSM: accept one strobe in IDLE, spend exactly one cycle in ACK.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i && (io_hit_s || int_hit_s)) begin
                    state_next_s = ST_ACK;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                    accept_s     = 1'b0;
                end
            end
            ST_ACK: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign io_acc_s  = accept_s && io_hit_s;
    assign int_acc_s = accept_s && int_hit_s;
    assign wr_s      = io_acc_s && wb_we_i;

    // Register read mux (pre-write values, so a write also returns old data).
    always_comb begin
        rd_data_s = 8'h00;
        case (offset_s)
            2'd0:    rd_data_s = pend_r;
            2'd1:    rd_data_s = mask_r;
            2'd2:    rd_data_s = vbase_r;
            2'd3:    rd_data_s = ctrl_rd_s;
            default: rd_data_s = 8'h00;
        endcase
    end

    // Mode-2 vector: even slot per source, 4'hF marks a spurious acknowledge.
    always_comb begin
        vector_s = 8'h00;
        if (any_active_s) begin
            vector_s = {vbase_r[7:4], idx_s, 1'b0};
        end else begin
            vector_s = {vbase_r[7:4], 4'hF};
        end
    end

    // Data presented on the accepted cycle: vector for acks, register otherwise.
    always_comb begin
        out_data_s = 8'h00;
        if (int_hit_s) begin
            out_data_s = vector_s;
        end else begin
            out_data_s = rd_data_s;
        end
    end

    // PEND clear sources; a same-cycle edge always wins over either clear.
    always_comb begin
        pend_w1c_s     = 8'h00;
        pend_ack_clr_s = 8'h00;
        if (wr_s && (offset_s == 2'd0)) begin
            pend_w1c_s = wb_dat_i;
        end else begin
            pend_w1c_s = 8'h00;
        end
        if (int_acc_s && any_active_s) begin
            pend_ack_clr_s = 8'h01 << idx_s;
        end else begin
            pend_ack_clr_s = 8'h00;
        end
        pend_next_s = (pend_r & ~(pend_w1c_s | pend_ack_clr_s)) | edge_s;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Slave FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Edge-detect delay line and pending-request latch.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_d_r <= 8'h00;
            pend_r  <= 8'h00;
        end else begin
            irq_d_r <= irq_i;
            pend_r  <= pend_next_s;
        end
    end

    // Software-writable configuration registers (MASK, VBASE, EN).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mask_r  <= 8'hFF;
            vbase_r <= 8'h00;
            en_r    <= 1'b0;
        end else if (wr_s) begin
            case (offset_s)
                2'd1:    mask_r  <= wb_dat_i;
                2'd2:    vbase_r <= wb_dat_i;
                2'd3:    en_r    <= wb_dat_i[0];
                default: mask_r  <= mask_r;
            endcase
        end else begin
            mask_r <= mask_r;
        end
    end

    // Acknowledge bookkeeping: LAST/VALID record the outcome of each ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            valid_r <= 1'b0;
            last_r  <= 3'd0;
        end else if (int_acc_s) begin
            if (any_active_s) begin
                valid_r <= 1'b1;
                last_r  <= idx_s;
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Bus response: one ack pulse per accepted strobe, data held otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 8'h00;
        end else if (accept_s) begin
            ack_r <= 1'b1;
            dat_r <= out_data_s;
        end else begin
            ack_r <= 1'b0;
        end
    end

    // Interrupt request to the core, one cycle behind PEND/MASK/EN.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            int_req_r <= 1'b0;
        end else begin
            int_req_r <= en_r & any_active_s;
        end
    end

    assign wb_ack_o  = ack_r;
    assign wb_dat_o  = dat_r;
    assign int_req_o = int_req_r;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Bench for z80_int_ctrl: register-access vector table, hand-written
// sequences for priority, masking, collisions and decode/reset, then random
// traffic checked every cycle against a behavioural model of the controller.

module tb_z80_int_ctrl;

    localparam logic [1:0] TIO  = 2'b01;
    localparam logic [1:0] TINT = 2'b10;
    localparam logic [1:0] TMEM = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [1:0]  tga;
    logic        ack;
    logic [7:0]  irq;
    logic        int_req;

    int checks = 0;
    int errors = 0;

    z80_int_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
        .wb_dat_o  (dat_o),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_tga_i  (tga),
        .wb_ack_o  (ack),
        .irq_i     (irq),
        .int_req_o (int_req)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [7:0] m_pend, m_mask, m_vbase, m_irqd, m_dat;
    logic       m_en, m_valid, m_busy, m_ack, m_int;
    logic [2:0] m_last;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'hFF; m_vbase = 8'h00; m_irqd = 8'h00;
        m_dat = 8'h00; m_en = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
        m_ack = 1'b0; m_int = 1'b0; m_last = 3'd0;
    endtask

    // Highest-priority (lowest-numbered) requesting source, or -1 if none.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance model and DUT by one clock with the current inputs, then compare.
    task automatic step();
        logic [7:0] act, clr;
        logic       isio, sel, n_int;
        int         k;
        act   = m_pend & ~m_mask;
        k     = lowest(act);
        isio  = (tga == TIO) && (adr[7:2] == 6'h3C);
        sel   = cyc && stb && !m_busy && (isio || tga == TINT);
        n_int = m_en && (act != 8'h00);
        clr   = 8'h00;
        if (sel && isio) begin
            case (adr[1:0])
                2'd0: m_dat = m_pend;
                2'd1: m_dat = m_mask;
                2'd2: m_dat = m_vbase;
                default: m_dat = {1'b0, m_last, m_valid, 2'b00, m_en};
            endcase
            if (we) begin
                case (adr[1:0])
                    2'd0: clr = dat_i;
                    2'd1: m_mask = dat_i;
                    2'd2: m_vbase = dat_i;
                    default: m_en = dat_i[0];
                endcase
            end
        end else if (sel) begin
            if (k >= 0) begin
                m_dat   = {m_vbase[7:4], 3'(k), 1'b0};
                clr[k]  = 1'b1;
                m_last  = 3'(k);
                m_valid = 1'b1;
            end else begin
                m_dat   = {m_vbase[7:4], 4'hF};
                m_valid = 1'b0;
            end
        end
        m_pend = (m_pend & ~clr) | (irq & ~m_irqd);
        m_irqd = irq;
        m_busy = sel;
        m_ack  = sel;
        m_int  = n_int;
        @(posedge clk);
        #1;
        check("model_ack", {7'b0, ack}, {7'b0, m_ack});
        check("model_dat", dat_o, m_dat);
        check("model_int_req", {7'b0, int_req}, {7'b0, m_int});
    endtask

    // One complete Wishbone transfer: strobe, ack cycle, then strobe dropped.
    task automatic bus(input logic [1:0] t, input logic [15:0] a, input logic w,
                       input logic [7:0] d, output logic [7:0] rd);
        tga = t; adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
        step();
        rd = dat_o;
        check("ack_pulse", {7'b0, ack}, 8'h01);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
        check("ack_single", {7'b0, ack}, 8'h00);
    endtask

    typedef struct {
        logic [1:0] off;
        logic       wr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[12];
    logic [7:0] rd;

    initial begin
        rst = 1'b1; adr = 16'h0000; dat_i = 8'h00; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; tga = TMEM; irq = 8'h00;
        model_reset();

        // Register access table: offset, write?, write data, expected read data.
        tbl[0]  = '{2'd0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{2'd1, 1'b0, 8'h00, 8'hFF};
        tbl[2]  = '{2'd2, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{2'd3, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{2'd2, 1'b1, 8'hA0, 8'h00};
        tbl[5]  = '{2'd1, 1'b1, 8'h00, 8'hFF};
        tbl[6]  = '{2'd3, 1'b1, 8'hFF, 8'h00};
        tbl[7]  = '{2'd3, 1'b0, 8'h00, 8'h01};
        tbl[8]  = '{2'd3, 1'b1, 8'h01, 8'h01};
        tbl[9]  = '{2'd2, 1'b0, 8'h00, 8'hA0};
        tbl[10] = '{2'd1, 1'b0, 8'h00, 8'h00};
        tbl[11] = '{2'd0, 1'b1, 8'hFF, 8'h00};

        #12;
        check("reset_ack", {7'b0, ack}, 8'h00);
        check("reset_dat", dat_o, 8'h00);
        check("reset_int_req", {7'b0, int_req}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus(TIO, {8'h00, 6'h3C, tbl[i].off}, tbl[i].wr, tbl[i].wdat, rd);
            check($sformatf("tbl_%0d", i), rd, tbl[i].exp);
            check("tbl_int_req", {7'b0, int_req}, 8'h00);
        end

        // Single source on irq[5].
        irq = 8'h20; step();
        check("single_req_lag", {7'b0, int_req}, 8'h00);
        irq = 8'h00; step();
        check("single_req", {7'b0, int_req}, 8'h01);
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("single_pend", rd, 8'h20);
        tga = TINT; adr = 16'h0000; cyc = 1'b1; stb = 1'b1;
        step();
        check("single_vector", dat_o, 8'hAA);
        cyc = 1'b0; stb = 1'b0;
        step();
        check("single_req_drop", {7'b0, int_req}, 8'h00);
        bus(TIO, 16'h00F3, 1'b0, 8'h00, rd);
        check("single_ctrl", rd, 8'h59);

        // Priority: irq[6] and irq[2] together.
        irq = 8'h44; step();
        irq = 8'h00; step();
        bus(TINT, 16'h0000, 1'b0, 8'h00, rd);
        check("prio_first", rd, 8'hA4);
        bus(TINT, 16'h0000, 1'b0, 8'h00, rd);
        check("prio_second", rd, 8'hAC);
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("prio_pend", rd, 8'h00);

        // Masking and spurious acknowledge.
        bus(TIO, 16'h00F1, 1'b1, 8'h08, rd);
        irq = 8'h08; step();
        irq = 8'h00; step(); step();
        check("mask_no_req", {7'b0, int_req}, 8'h00);
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("mask_pend", rd, 8'h08);
        bus(TINT, 16'h0000, 1'b0, 8'h00, rd);
        check("spurious_vector", rd, 8'hAF);
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("spurious_pend", rd, 8'h08);
        bus(TIO, 16'h00F3, 1'b0, 8'h00, rd);
        check("spurious_valid", {7'b0, rd[3]}, 8'h00);
        check("spurious_ctrl", rd, 8'h61);

        // Collision: W1C of bit 0 in the same cycle as a new edge on irq[0].
        irq = 8'h01;
        bus(TIO, 16'h00F0, 1'b1, 8'h01, rd);
        irq = 8'h00;
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("collide_w1c", rd, 8'h09);
        // Collision: ack clearing bit 0 in the same cycle as a new edge.
        irq = 8'h01;
        bus(TINT, 16'h0000, 1'b0, 8'h00, rd);
        check("collide_ack_vec", rd, 8'hA0);
        irq = 8'h00;
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd);
        check("collide_ack", rd, 8'h09);

        // Decode: memory cycle and out-of-window I/O cycle get no ack.
        tga = TMEM; adr = 16'h00F0; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mem_no_ack", {7'b0, ack}, 8'h00);
        end
        tga = TIO; adr = 16'h12F4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("window_no_ack", {7'b0, ack}, 8'h00);
        end

        // Reset asserted in the middle of an ack cycle.
        cyc = 1'b0; stb = 1'b0; step();
        tga = TIO; adr = 16'h00F1; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        step();
        check("pre_reset_ack", {7'b0, ack}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_ack", {7'b0, ack}, 8'h00);
        check("midreset_dat", dat_o, 8'h00);
        check("midreset_int_req", {7'b0, int_req}, 8'h00);
        cyc = 1'b0; stb = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus(TIO, 16'h00F0, 1'b0, 8'h00, rd); check("post_reset_pend", rd, 8'h00);
        bus(TIO, 16'h00F1, 1'b0, 8'h00, rd); check("post_reset_mask", rd, 8'hFF);
        bus(TIO, 16'h00F2, 1'b0, 8'h00, rd); check("post_reset_vbase", rd, 8'h00);
        bus(TIO, 16'h00F3, 1'b0, 8'h00, rd); check("post_reset_ctrl", rd, 8'h00);

        // Random traffic against the model.
        bus(TIO, 16'h00F3, 1'b1, 8'h01, rd);
        bus(TIO, 16'h00F1, 1'b1, 8'h00, rd);
        for (int n = 0; n < 800; n++) begin
            irq   = 8'($urandom);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 1) != 0);
            we    = ($urandom_range(0, 2) == 0);
            dat_i = 8'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    tga = TIO;
                2, 3:    tga = TINT;
                4:       tga = TMEM;
                default: tga = 2'b11;
            endcase
            if ($urandom_range(0, 3) != 0) begin
                adr = {8'($urandom), 6'h3C, 2'($urandom)};
            end else begin
                adr = 16'($urandom);
            end
            step();
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
